seg7_result_display: RTL and testbench

Display-side consumer of the calculator control FSM's `ValueOut`/`Display`/`Overflow` outputs. It converts the 8-bit unsigned value to three decimal digits with a sequential shift-add-3 (double-dabble) engine. It also decodes the 3-bit display code into a mode label and time-multiplexes a 4-digit common-anode seven-segment panel. It sits between the control FSM and the board pins.

---
 rtl/seg7_result_display_if.sv | 15 +
 rtl/seg7_result_display.sv | 192 +++++++++++++++++++
 tb/tb_seg7_result_display.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_result_display_if.sv
// Source-side bus between the calculator control FSM and the display block.
//   ValueIn     : unsigned value to show (0-255)
//   DisplayCode : mode code selecting the label / blanking
//   Overflow    : ALU overflow flag, shown only in mode 3'b011
//   Busy        : display block is converting a new tuple
// master = control FSM side, slave = display side.
interface seg7_result_display_if;
  logic [7:0] ValueIn;
  logic [2:0] DisplayCode;
  logic       Overflow;
  logic       Busy;

  modport master (output ValueIn, output DisplayCode, output Overflow, input Busy);
  modport slave  (input ValueIn, input DisplayCode, input Overflow, output Busy);
endinterface

// File: rtl/seg7_result_display.sv
// Converts an 8-bit value to three BCD digits with a sequential
// shift-add-3 engine and time-multiplexes a 4-digit common-anode panel.
//   clock        : system clock, rising edge
//   reset        : synchronous, active-high
//   src          : slave side of seg7_result_display_if (value/code/ovf in, Busy out)
//   Segments     : active-low segments, bit0 = a .. bit6 = g
//   DecimalPoint : active-low decimal point
//   DigitSel     : active-low one-hot digit enable, bit3 = leftmost
module seg7_result_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  seg7_result_display_if.slave  src,
  output logic [6:0]            Segments,
  output logic                  DecimalPoint,
  output logic [3:0]            DigitSel
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  typedef enum logic [3:0] {
    S_0, S_1, S_2, S_3, S_4, S_5, S_6, S_7, S_8, S_9,
    S_A, S_B, S_R, S_DASH, S_BLANK
  } sym_t;

  state_t      state, state_next;
  logic        accept, step, commit;

  logic        pending;
  logic [7:0]  src_val;
  logic [2:0]  src_code;
  logic        src_ovf;
  logic [19:0] shifter, shifter_adj;
  logic [2:0]  step_cnt;

  logic [3:0]  disp_h, disp_t, disp_u;
  logic [2:0]  disp_code;
  logic        disp_ovf;

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    idx, idx_next;
  logic          wrap;
  sym_t          sym;
  logic          dp_on;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] glyph(input sym_t s);
    case (s)
      S_0:     return 7'b1000000;
      S_1:     return 7'b1111001;
      S_2:     return 7'b0100100;
      S_3:     return 7'b0110000;
      S_4:     return 7'b0011001;
      S_5:     return 7'b0010010;
      S_6:     return 7'b0000010;
      S_7:     return 7'b1111000;
      S_8:     return 7'b0000000;
      S_9:     return 7'b0010000;
      S_A:     return 7'b0001000;
      S_B:     return 7'b0000011;
      S_R:     return 7'b0101111;
      S_DASH:  return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (pending ||
            {src.ValueIn, src.DisplayCode, src.Overflow} != {src_val, src_code, src_ovf}) begin
          accept     = 1'b1;
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        step = 1'b1;
        if (step_cnt == 3'd7) state_next = DONE;
      end
      DONE: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign src.Busy = (state != IDLE);

  // Correct every BCD nibble before the shift so the carry lands in decimal.
  always_comb begin
    shifter_adj = {add3(shifter[19:16]), add3(shifter[15:12]), add3(shifter[11:8]), shifter[7:0]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending   <= 1'b1;
      src_val   <= '0;
      src_code  <= '0;
      src_ovf   <= 1'b0;
      shifter   <= '0;
      step_cnt  <= '0;
      disp_h    <= '0;
      disp_t    <= '0;
      disp_u    <= '0;
      disp_code <= '0;
      disp_ovf  <= 1'b0;
    end else begin
      if (accept) begin
        src_val  <= src.ValueIn;
        src_code <= src.DisplayCode;
        src_ovf  <= src.Overflow;
        shifter  <= {12'b0, src.ValueIn};
        pending  <= 1'b0;
        step_cnt <= '0;
      end
      if (step) begin
        shifter  <= {shifter_adj[18:0], 1'b0};
        step_cnt <= step_cnt + 3'd1;
      end
      if (commit) begin
        disp_h    <= shifter[19:16];
        disp_t    <= shifter[15:12];
        disp_u    <= shifter[11:8];
        disp_code <= src_code;
        disp_ovf  <= src_ovf;
      end
    end
  end

  // ---------------- scanning ----------------
  assign wrap     = (refresh_cnt == CW'(REFRESH_DIV - 1));
  assign idx_next = wrap ? idx + 2'd1 : idx;

  // Content is decoded for the digit selected after this edge so that
  // DigitSel, Segments and DecimalPoint all switch together.
  always_comb begin
    sym   = S_BLANK;
    dp_on = 1'b0;
    case (disp_code)
      3'b100: sym = S_DASH;
      3'b001, 3'b010, 3'b011, 3'b101: begin
        case (idx_next)
          2'd3: begin
            if (disp_code == 3'b010)      sym = S_B;
            else if (disp_code == 3'b011) sym = S_R;
            else                          sym = S_A;
          end
          2'd2:    sym = (disp_h == 4'd0) ? S_BLANK : sym_t'(disp_h);
          2'd1:    sym = (disp_h == 4'd0 && disp_t == 4'd0) ? S_BLANK : sym_t'(disp_t);
          default: sym = sym_t'(disp_u);
        endcase
        dp_on = (disp_code == 3'b011 && disp_ovf && idx_next == 2'd0) ||
                (disp_code == 3'b101 && idx_next == 2'd3);
      end
      default: sym = S_BLANK;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt  <= '0;
      idx          <= '0;
      DigitSel     <= 4'b1110;
      Segments     <= 7'b1111111;
      DecimalPoint <= 1'b1;
    end else begin
      refresh_cnt  <= wrap ? '0 : refresh_cnt + CW'(1);
      idx          <= idx_next;
      DigitSel     <= ~(4'b0001 << idx_next);
      Segments     <= glyph(sym);
      DecimalPoint <= ~dp_on;
    end
  end

endmodule

// File: tb/tb_seg7_result_display.sv
module tb_seg7_result_display;
  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Segments;
  logic       DecimalPoint;
  logic [3:0] DigitSel;

  seg7_result_display_if bus();

  seg7_result_display #(.REFRESH_DIV(DIV)) dut (
    .clock(clock), .reset(reset), .src(bus),
    .Segments(Segments), .DecimalPoint(DecimalPoint), .DigitSel(DigitSel)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  string dig_lit[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                         "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic logic [6:0] seg_mask(string lit);
    logic [6:0] m = 7'h7f;
    for (int i = 0; i < lit.len(); i++) m[int'(lit[i]) - 97] = 1'b0;
    return m;
  endfunction

  // {sel, dp, seg} expected for scan position idx showing (v, code, ovf)
  function automatic logic [11:0] render(int idx, int v, int code, bit ovf);
    string g[4];
    bit dp;
    int h, t, u;
    logic [3:0] sel;
    for (int i = 0; i < 4; i++) g[i] = "";
    h = v / 100; t = (v / 10) % 10; u = v % 10;
    case (code)
      4: for (int i = 0; i < 4; i++) g[i] = "g";
      1, 2, 3, 5: begin
        g[3] = (code == 2) ? "cdefg" : (code == 3) ? "eg" : "abcefg";
        g[2] = (h == 0) ? "" : dig_lit[h];
        g[1] = (h == 0 && t == 0) ? "" : dig_lit[t];
        g[0] = dig_lit[u];
      end
      default: ;
    endcase
    dp = (code == 3 && ovf && idx == 0) || (code == 5 && idx == 3);
    sel = 4'hf;
    sel[idx] = 1'b0;
    return {sel, ~dp, seg_mask(g[idx])};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         model_valid = 0;
  bit         m_pending;
  int         m_busy_cnt;
  int         m_src_val, m_src_code;
  bit         m_src_ovf;
  int         m_disp_val, m_disp_code;
  bit         m_disp_ovf;
  int         m_tick;
  logic [11:0] exp_out;
  bit         exp_busy;

  always @(posedge clock) begin
    int sv, sc; bit so;
    if (reset) begin
      model_valid = 1;
      m_pending = 1; m_busy_cnt = 0;
      m_src_val = 0; m_src_code = 0; m_src_ovf = 0;
      m_disp_val = 0; m_disp_code = 0; m_disp_ovf = 0;
      m_tick = 0;
      exp_out = {4'b1110, 1'b1, 7'h7f};
      exp_busy = 0;
    end else if (model_valid) begin
      sv = m_disp_val; sc = m_disp_code; so = m_disp_ovf;
      if (m_busy_cnt == 0) begin
        if (m_pending || int'(bus.ValueIn) != m_src_val ||
            int'(bus.DisplayCode) != m_src_code || bus.Overflow != m_src_ovf) begin
          m_src_val = bus.ValueIn; m_src_code = bus.DisplayCode; m_src_ovf = bus.Overflow;
          m_pending = 0;
          m_busy_cnt = 9;
        end
      end else begin
        m_busy_cnt--;
        if (m_busy_cnt == 0) begin
          m_disp_val = m_src_val; m_disp_code = m_src_code; m_disp_ovf = m_src_ovf;
        end
      end
      m_tick++;
      exp_out = render((m_tick / DIV) % 4, sv, sc, so);
      exp_busy = (m_busy_cnt != 0);
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      chk("DigitSel", DigitSel, exp_out[11:8]);
      chk("DecimalPoint", DecimalPoint, exp_out[7]);
      chk("Segments", Segments, exp_out[6:0]);
      chk("Busy", bus.Busy, exp_busy);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic set_in(input int v, input int c, input bit o);
    @(negedge clock);
    bus.ValueIn = 8'(v); bus.DisplayCode = 3'(c); bus.Overflow = o;
  endtask

  task automatic expect_digit(input string name, input logic [3:0] sel,
                              input logic [6:0] seg, input logic dp);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock);
      if (DigitSel == sel) ok = 1;
    end
    if (!ok) chk({name, " select timeout"}, 0, 1);
    else begin
      chk({name, " seg"}, Segments, seg);
      chk({name, " dp"}, DecimalPoint, dp);
    end
  endtask

  initial begin
    int busy_cycles;
    bus.ValueIn = 8'd0; bus.DisplayCode = 3'b100; bus.Overflow = 1'b0;
    repeat (2) @(negedge clock);
    reset = 0;

    // idle dashes
    repeat (12) @(negedge clock);
    expect_digit("dash d0", 4'b1110, 7'b0111111, 1'b1);
    expect_digit("dash d1", 4'b1101, 7'b0111111, 1'b1);
    expect_digit("dash d3", 4'b0111, 7'b0111111, 1'b1);

    // 255 in mode A
    set_in(255, 3'b001, 0);
    repeat (12) @(negedge clock);
    expect_digit("255 d0", 4'b1110, 7'b0010010, 1'b1);
    expect_digit("255 d1", 4'b1101, 7'b0010010, 1'b1);
    expect_digit("255 d2", 4'b1011, 7'b0100100, 1'b1);
    expect_digit("255 d3", 4'b0111, 7'b0001000, 1'b1);

    // leading-zero blanking in mode b
    set_in(7, 3'b010, 0);
    repeat (12) @(negedge clock);
    expect_digit("7 d0", 4'b1110, 7'b1111000, 1'b1);
    expect_digit("7 d1", 4'b1101, 7'b1111111, 1'b1);
    expect_digit("7 d2", 4'b1011, 7'b1111111, 1'b1);
    expect_digit("7 d3", 4'b0111, 7'b0000011, 1'b1);
    set_in(0, 3'b010, 0);
    repeat (12) @(negedge clock);
    expect_digit("0 d0", 4'b1110, 7'b1000000, 1'b1);
    set_in(100, 3'b010, 0);
    repeat (12) @(negedge clock);
    expect_digit("100 d0", 4'b1110, 7'b1000000, 1'b1);
    expect_digit("100 d1", 4'b1101, 7'b1000000, 1'b1);
    expect_digit("100 d2", 4'b1011, 7'b1111001, 1'b1);

    // decimal points
    set_in(200, 3'b011, 1);
    repeat (12) @(negedge clock);
    expect_digit("ovf d0", 4'b1110, 7'b1000000, 1'b0);
    expect_digit("ovf d1", 4'b1101, 7'b1000000, 1'b1);
    expect_digit("ovf d3", 4'b0111, 7'b0101111, 1'b1);
    set_in(200, 3'b101, 1);
    repeat (12) @(negedge clock);
    expect_digit("chain d0", 4'b1110, 7'b1000000, 1'b1);
    expect_digit("chain d3", 4'b0111, 7'b0001000, 1'b0);

    // change during conversion: exactly two conversions
    set_in(10, 3'b001, 0);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i == 2) bus.ValueIn = 8'd42;
      if (bus.Busy) busy_cycles++;
    end
    chk("two conversions busy cycles", busy_cycles, 18);
    expect_digit("42 d0", 4'b1110, 7'b0100100, 1'b1);
    expect_digit("42 d1", 4'b1101, 7'b0011001, 1'b1);
    expect_digit("42 d2", 4'b1011, 7'b1111111, 1'b1);

    // reset mid-conversion
    set_in(77, 3'b010, 0);
    @(posedge clock);
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    chk("rst DigitSel", DigitSel, 4'b1110);
    chk("rst Segments", Segments, 7'b1111111);
    chk("rst DecimalPoint", DecimalPoint, 1);
    chk("rst Busy", bus.Busy, 0);
    reset = 0;
    @(negedge clock);
    chk("forced conversion Busy", bus.Busy, 1);
    repeat (12) @(negedge clock);
    expect_digit("77 d0", 4'b1110, 7'b1111000, 1'b1);
    expect_digit("77 d3", 4'b0111, 7'b0000011, 1'b1);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      @(negedge clock);
      if ($urandom_range(0, 3) != 0) bus.ValueIn = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) bus.DisplayCode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) bus.Overflow = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 20)) @(negedge clock);
    end
    repeat (30) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
